// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives blocking I-cache requests and feeds decode
// through a registered slot plus a one-entry skid buffer. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SQUASH = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        icache_req_q, icache_req_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        slot_free_s;
  logic        consume_s;

  assign consume_s   = if_valid_q & ~stall;
  assign slot_free_s = ~if_valid_q | ~stall;

  // Next-state, PC and slot/skid update; redirect overrides stall and any capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (consume_s) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end else begin
      if_valid_d = if_valid_q;
    end
    if (redirect_valid) begin
      if_valid_d   = 1'b0;
      if_instr_d   = NOP_INSTR;
      skid_valid_d = 1'b0;
      pc_d         = redirect_pc;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          state_d    = ST_REQ;
          req_addr_d = redirect_pc;
        end
        // An outstanding miss cannot be aborted, so its response must be drained first.
        ST_REQ, ST_SQUASH: begin
          if (icache_valid) begin
            state_d    = ST_REQ;
            req_addr_d = redirect_pc;
          end else begin
            state_d = ST_SQUASH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_REQ;
          req_addr_d = pc_q;
        end
        ST_REQ: begin
          if (icache_valid && slot_free_s) begin
            if_valid_d = 1'b1;
            if_instr_d = icache_data;
            if_pc_d    = req_addr_q;
            pc_d       = req_addr_q + 32'd4;
            req_addr_d = pc_q + 32'd4;
          end else if (icache_valid) begin
            skid_valid_d = 1'b1;
            skid_instr_d = icache_data;
            skid_pc_d    = req_addr_q;
            pc_d         = pc_q + 32'd4;
            state_d      = ST_HOLD;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (consume_s) begin
            if_valid_d   = skid_valid_q;
            if_instr_d   = skid_instr_q;
            if_pc_d      = skid_pc_q;
            skid_valid_d = 1'b0;
            req_addr_d   = pc_q;
            state_d      = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_SQUASH: begin
          if (icache_valid) begin
            req_addr_d = pc_q;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_SQUASH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    icache_req_d = (state_d == ST_REQ) || (state_d == ST_SQUASH);
  end

  // Pipeline state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= 32'h0000_0000;
      icache_req_q <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      icache_req_q <= icache_req_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign icache_req     = icache_req_q;
  assign icache_addr    = req_addr_q;
  assign if_valid       = if_valid_q;
  assign if_instruction = if_instr_q;
  assign if_pc          = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  // Delivered-instruction and cache-wait counters, both wrapping.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_wait_d    = perf_wait_q;
    if (consume_s) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end else begin
      perf_fetched_d = perf_fetched_q;
    end
    if (((state_q == ST_REQ) || (state_q == ST_SQUASH)) && !icache_valid) begin
      perf_wait_d = perf_wait_q + 32'd1;
    end else begin
      perf_wait_d = perf_wait_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_wait_q    <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_wait_q    <= perf_wait_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_wait    = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable I-cache model.
module tb_fetch_stage;
  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_wait;

  int n_checks = 0;
  int n_errors = 0;
  int wcnt = 0;
  int lat = 1;
  int slow_lat = 1;
  logic [31:0] slow_addr = 32'h0000_0003;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_valid   (icache_valid),
    .icache_data    (icache_data),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .perf_fetched   (perf_fetched),
    .perf_wait      (perf_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cache responds once the request has been visible for its latency in cycles.
  task automatic cache_model();
    int need;
    if (icache_req === 1'b1) begin
      need = (icache_addr == slow_addr) ? slow_lat : lat;
      wcnt++;
      if (wcnt >= need) begin
        icache_valid = 1'b1;
        icache_data  = instr_of(icache_addr);
        wcnt = 0;
      end else begin
        icache_valid = 1'b0;
        icache_data  = 32'h0000_0000;
      end
    end else begin
      icache_valid = 1'b0;
      icache_data  = 32'h0000_0000;
      wcnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cache_model();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    icache_valid   = 1'b0;
    icache_data    = 32'h0000_0000;
    wcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cache_model();
  endtask

  initial begin
    // 1: reset state and back-to-back single-cycle hits
    lat = 1;
    do_reset();
    check("rst_req", {31'd0, icache_req}, 32'd0);
    check("rst_addr", icache_addr, 32'h0000_0000);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instruction, NOP);
    check("rst_pc", if_pc, 32'h0000_0000);
    check("rst_pf", perf_fetched, 32'd0);
    check("rst_pw", perf_wait, 32'd0);
    step();
    check("t1_req", {31'd0, icache_req}, 32'd1);
    check("t1_addr", icache_addr, 32'h0000_1000);
    check("t1_nv", {31'd0, if_valid}, 32'd0);
    step();
    check("t1_v0", {31'd0, if_valid}, 32'd1);
    check("t1_pc0", if_pc, 32'h0000_1000);
    check("t1_in0", if_instruction, instr_of(32'h0000_1000));
    step();
    check("t1_pc1", if_pc, 32'h0000_1004);
    step();
    check("t1_pc2", if_pc, 32'h0000_1008);
    check("t1_in2", if_instruction, instr_of(32'h0000_1008));
    check("t1_pf", perf_fetched, perf_exp(32'd2));
    check("t1_pw", perf_wait, perf_exp(32'd0));

    // 2: five-cycle miss holds the request stable
    lat = 5;
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2_req", {31'd0, icache_req}, 32'd1);
      check("t2_addr", icache_addr, 32'h0000_1000);
      check("t2_nv", {31'd0, if_valid}, 32'd0);
      step();
    end
    check("t2_v", {31'd0, if_valid}, 32'd1);
    check("t2_pc", if_pc, 32'h0000_1000);
    check("t2_pw", perf_wait, perf_exp(32'd4));

    // 3: stall forces the returning word into the skid buffer
    lat = 1;
    do_reset();
    step();
    step();
    step();
    check("t3_pc", if_pc, 32'h0000_1004);
    check("t3_addr", icache_addr, 32'h0000_1008);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hreq", {31'd0, icache_req}, 32'd0);
      check("t3_hv", {31'd0, if_valid}, 32'd1);
      check("t3_hpc", if_pc, 32'h0000_1004);
    end
    stall = 1'b0;
    step();
    check("t3_skpc", if_pc, 32'h0000_1008);
    check("t3_skin", if_instruction, instr_of(32'h0000_1008));
    check("t3_rreq", {31'd0, icache_req}, 32'd1);
    check("t3_raddr", icache_addr, 32'h0000_100C);
    step();
    check("t3_npc", if_pc, 32'h0000_100C);
    check("t3_pf", perf_fetched, perf_exp(32'd3));

    // 4: redirect during an outstanding miss squashes it
    lat = 1;
    slow_addr = 32'h0000_1010;
    slow_lat = 3;
    do_reset();
    repeat (5) step();
    check("t4_addr", icache_addr, 32'h0000_1010);
    check("t4_pc", if_pc, 32'h0000_100C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    check("t4_sv", {31'd0, if_valid}, 32'd0);
    check("t4_sin", if_instruction, NOP);
    check("t4_sreq", {31'd0, icache_req}, 32'd1);
    check("t4_saddr", icache_addr, 32'h0000_1010);
    step();
    check("t4_sv2", {31'd0, if_valid}, 32'd0);
    check("t4_saddr2", icache_addr, 32'h0000_1010);
    step();
    check("t4_dv", {31'd0, if_valid}, 32'd0);
    check("t4_nreq", {31'd0, icache_req}, 32'd1);
    check("t4_naddr", icache_addr, 32'h0000_2000);
    step();
    check("t4_v", {31'd0, if_valid}, 32'd1);
    check("t4_vpc", if_pc, 32'h0000_2000);
    check("t4_pw", perf_wait, perf_exp(32'd2));
    slow_addr = 32'h0000_0003;

    // 5: redirect with a same-cycle response under stall drops the response
    lat = 1;
    do_reset();
    step();
    step();
    check("t5_pc", if_pc, 32'h0000_1000);
    check("t5_addr", icache_addr, 32'h0000_1004);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    check("t5_nv", {31'd0, if_valid}, 32'd0);
    check("t5_nin", if_instruction, NOP);
    check("t5_req", {31'd0, icache_req}, 32'd1);
    check("t5_raddr", icache_addr, 32'h0000_2000);
    step();
    check("t5_v", {31'd0, if_valid}, 32'd1);
    check("t5_vpc", if_pc, 32'h0000_2000);
    stall = 1'b0;
    step();
    check("t5_npc", if_pc, 32'h0000_2004);

    // 6: PC wraps from the top of the address space
    lat = 1;
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("t6_addr", icache_addr, 32'hFFFF_FFFC);
    check("t6_nv", {31'd0, if_valid}, 32'd0);
    step();
    check("t6_pc", if_pc, 32'hFFFF_FFFC);
    check("t6_in", if_instruction, instr_of(32'hFFFF_FFFC));
    check("t6_wrap", icache_addr, 32'h0000_0000);
    step();
    check("t6_pc0", if_pc, 32'h0000_0000);

    // 7: asynchronous reset in the middle of a request
    lat = 10;
    do_reset();
    step();
    step();
    check("t7_req", {31'd0, icache_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("t7_rreq", {31'd0, icache_req}, 32'd0);
    check("t7_raddr", icache_addr, 32'h0000_0000);
    check("t7_rv", {31'd0, if_valid}, 32'd0);
    lat = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wcnt = 0;
    cache_model();
    step();
    check("t7_areq", {31'd0, icache_req}, 32'd1);
    check("t7_aaddr", icache_addr, 32'h0000_1000);
    step();
    check("t7_pc", if_pc, 32'h0000_1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
